// File: rtl/lisnoc_router_output_arb_pkg.sv
// Shared flit-type encoding for the lisnoc router stages.
// Type bits sit directly above the payload: bit 1 marks the last flit, bit 0 the first.
package lisnoc_router_output_arb_pkg;

    localparam int FLIT_TYPE_W    = 2;
    localparam int TYPE_LAST_OFS  = 1;
    localparam int TYPE_FIRST_OFS = 0;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_TYPE_PAYLOAD = 2'b00,
        FLIT_TYPE_HEADER  = 2'b01,
        FLIT_TYPE_LAST    = 2'b10,
        FLIT_TYPE_SINGLE  = 2'b11
    } flit_type_e;

    function automatic logic type_is_last(input logic [FLIT_TYPE_W-1:0] flit_type);
        return flit_type[TYPE_LAST_OFS];
    endfunction

endpackage

// File: rtl/lisnoc_router_arb_rr.sv
// Combinational round-robin selector: grants the first requester at or after the
// one-hot priority pointer, wrapping, and reports the pointer just past the grant.
module lisnoc_router_arb_rr #(
    parameter int ports = 5
) (
    input  logic [ports-1:0] req,
    input  logic [ports-1:0] prio,
    output logic [ports-1:0] gnt,
    output logic [ports-1:0] nxt_prio
);

    logic [ports-1:0]   req_hi_s;
    logic [ports-1:0]   gnt_hi_s;
    logic [ports-1:0]   gnt_lo_s;
    logic [2*ports-1:0] gnt_dbl_s;

    // Requesters at or above the pointer win first; otherwise wrap to the lowest requester.
    always_comb begin
        req_hi_s = req & ~(prio - ports'(1));
        gnt_hi_s = req_hi_s & (~req_hi_s + ports'(1));
        gnt_lo_s = req & (~req + ports'(1));
        if (|req_hi_s) begin
            gnt = gnt_hi_s;
        end else begin
            gnt = gnt_lo_s;
        end
    end

    // Rotate the grant left by one position to point at the following input.
    always_comb begin
        gnt_dbl_s = {gnt, gnt};
        if (|gnt) begin
            nxt_prio = ports'(gnt_dbl_s >> (ports - 1));
        end else begin
            nxt_prio = prio;
        end
    end

endmodule

// File: rtl/lisnoc_router_output_arb.sv
// Output-port arbitration for a lisnoc router: round-robin between inputs, locked
// to one input for the duration of a packet, feeding a single-entry output register.
module lisnoc_router_output_arb
    import lisnoc_router_output_arb_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ports           = 5
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [ports-1:0]                                  switch_request,
    input  logic [ports*(flit_data_width+flit_type_width)-1:0] switch_flit,
    output logic [ports-1:0]                                  switch_read,
    output logic [flit_data_width+flit_type_width-1:0]        out_flit,
    output logic                                              out_valid,
    input  logic                                              out_ready
);

    localparam int FW = flit_data_width + flit_type_width;
    localparam logic [ports-1:0] PRIO_INIT = ports'(1'b1);

    logic              locked_r;
    logic [ports-1:0]  owner_r;
    logic [ports-1:0]  prio_r;
    logic [FW-1:0]     out_flit_r;
    logic              out_valid_r;

    logic              space_s;
    logic [ports-1:0]  rr_req_s;
    logic [ports-1:0]  rr_prio_s;
    logic [ports-1:0]  sel_s;
    logic [ports-1:0]  nxt_prio_s;
    logic [FW-1:0]     sel_flit_s;
    logic              sel_last_s;
    logic              xfer_s;

    // While locked, only the owner may win; pointing the arbiter at the owner makes
    // its next-pointer output land just past the owner when the packet ends.
    always_comb begin
        if (locked_r) begin
            rr_req_s  = owner_r & switch_request;
            rr_prio_s = owner_r;
        end else begin
            rr_req_s  = switch_request;
            rr_prio_s = prio_r;
        end
    end

    lisnoc_router_arb_rr #(
        .ports    (ports)
    ) u_arb_rr (
        .req      (rr_req_s),
        .prio     (rr_prio_s),
        .gnt      (sel_s),
        .nxt_prio (nxt_prio_s)
    );

    // Acknowledge only when the output register can take a flit; held off while in reset.
    always_comb begin
        space_s = ~out_valid_r | out_ready;
        if (space_s && rst) begin
            switch_read = sel_s;
        end else begin
            switch_read = '0;
        end
        xfer_s = |switch_read;
    end

    // One-hot flit multiplexer over the input slices.
    always_comb begin
        sel_flit_s = '0;
        for (int i = 0; i < ports; i++) begin
            if (sel_s[i]) begin
                sel_flit_s = sel_flit_s | switch_flit[i*FW +: FW];
            end else begin
                sel_flit_s = sel_flit_s;
            end
        end
        sel_last_s = type_is_last(sel_flit_s[flit_data_width +: FLIT_TYPE_W]);
    end

    // Lock/owner/pointer state and the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked_r    <= 1'b0;
            owner_r     <= '0;
            prio_r      <= PRIO_INIT;
            out_flit_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_flit_r  <= sel_flit_s;
            out_valid_r <= 1'b1;
            if (sel_last_s) begin
                locked_r <= 1'b0;
                prio_r   <= nxt_prio_s;
            end else begin
                locked_r <= 1'b1;
                owner_r  <= sel_s;
            end
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_flit  = out_flit_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_lisnoc_router_output_arb.sv
// Bench for lisnoc_router_output_arb: directed scenarios plus random traffic, all
// checked against an index-based packet-level model of the arbiter.
module tb_lisnoc_router_output_arb;

    localparam int DW = 32;
    localparam int TW = 2;
    localparam int NP = 5;
    localparam int FW = DW + TW;
    localparam logic [1:0] PAY = 2'b00, HDR = 2'b01, LST = 2'b10, SGL = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req;
    logic [NP*FW-1:0]  switch_flit;
    logic [NP-1:0]     switch_read;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [FW-1:0]     src_flit [NP];

    int n_checks = 0;
    int n_errors = 0;

    bit            mlocked, mvalid;
    int            mowner, mprio;
    logic [FW-1:0] mout;
    logic [NP-1:0] seen_read, last_read;

    int            len [NP];
    int            pos [NP];
    logic [31:0]   dat [NP];

    always #5 clk = ~clk;

    always_comb begin
        switch_flit = '0;
        for (int i = 0; i < NP; i++) switch_flit[i*FW +: FW] = src_flit[i];
    end

    lisnoc_router_output_arb #(
        .flit_data_width (DW),
        .flit_type_width (TW),
        .ports           (NP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .switch_request (req),
        .switch_flit    (switch_flit),
        .switch_read    (switch_read),
        .out_flit       (out_flit),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mlocked = 1'b0; mvalid = 1'b0; mowner = 0; mprio = 0; mout = '0;
    endtask

    // Expected acknowledge: owner only while a packet is open, else first requester from mprio.
    function automatic logic [NP-1:0] model_read();
        int sel = -1;
        if (mlocked) begin
            if (req[mowner]) sel = mowner;
        end else begin
            for (int k = 0; k < NP; k++) begin
                int idx = (mprio + k) % NP;
                if (sel < 0 && req[idx]) sel = idx;
            end
        end
        if ((!mvalid || out_ready) && sel >= 0) return NP'(1) << sel;
        return '0;
    endfunction

    task automatic cycle();
        logic [NP-1:0] er;
        int s;
        @(negedge clk);
        er = model_read();
        seen_read = switch_read;
        check_eq("read", switch_read, er);
        check_eq("valid", out_valid, mvalid);
        check_eq("flit", out_flit, mout);
        @(posedge clk);
        if (er != 0) begin
            s = 0;
            for (int i = 0; i < NP; i++) if (er[i]) s = i;
            mout = src_flit[s];
            mvalid = 1'b1;
            if (mout[FW-1]) begin
                mlocked = 1'b0;
                mprio = (s + 1) % NP;
            end else begin
                mlocked = 1'b1;
                mowner = s;
            end
        end else if (out_ready) begin
            mvalid = 1'b0;
        end
        last_read = er;
        #1;
    endtask

    task automatic do_reset();
        req = NP'($urandom);
        for (int i = 0; i < NP; i++) src_flit[i] = {SGL, 32'($urandom)};
        rst = 1'b0;
        model_reset();
        #2;
        check_eq("rst_read", switch_read, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_flit", out_flit, 0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_read", switch_read, 0);
        rst = 1'b1;
    endtask

    // Random sources: each input walks through packets of 1..4 flits, advancing on acknowledge.
    task automatic src_update(input logic [NP-1:0] consumed);
        logic [1:0] t;
        for (int i = 0; i < NP; i++) begin
            if (consumed[i]) begin
                pos[i]++;
                if (pos[i] == len[i]) begin
                    pos[i] = 0;
                    len[i] = $urandom_range(1, 4);
                end
                dat[i] = $urandom;
            end
            if (pos[i] == 0 && len[i] == 1) t = SGL;
            else if (pos[i] == 0)           t = HDR;
            else if (pos[i] == len[i] - 1)  t = LST;
            else                            t = PAY;
            src_flit[i] = {t, dat[i]};
            req[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        req = '0;
        for (int i = 0; i < NP; i++) src_flit[i] = '0;
        model_reset();
        #1;

        // Reset and first acknowledge
        do_reset();
        req = 5'b00100;
        src_flit[2] = {SGL, 32'h0000_00A5};
        cycle();
        check_eq("first_ack", seen_read, 5'b00100);
        check_eq("first_flit", out_flit, {SGL, 32'h0000_00A5});
        check_eq("first_valid", out_valid, 1);

        // Round-robin over singles
        do_reset();
        req = 5'b11111;
        for (int i = 0; i < NP; i++) src_flit[i] = {SGL, 32'h100 + 32'(i)};
        for (int c = 0; c < 6; c++) begin
            cycle();
            check_eq("rr_grant", seen_read, NP'(1) << (c % NP));
        end

        // Packet lock: input 1 holds the output while input 3 waits
        req = 5'b01010;
        src_flit[3] = {SGL, 32'h300};
        src_flit[1] = {HDR, 32'h11};
        cycle(); check_eq("lock_hdr", seen_read, 5'b00010);
        src_flit[1] = {PAY, 32'h12};
        cycle(); check_eq("lock_pay", seen_read, 5'b00010);
        src_flit[1] = {LST, 32'h13};
        cycle(); check_eq("lock_last", seen_read, 5'b00010);
        check_eq("lock_last_flit", out_flit, {LST, 32'h13});
        req = 5'b01000;
        cycle(); check_eq("lock_other", seen_read, 5'b01000);
        check_eq("lock_other_flit", out_flit, {SGL, 32'h300});

        // Bubble in the owner's packet
        req = 5'b00100;
        src_flit[2] = {HDR, 32'h21};
        cycle(); check_eq("bub_hdr", seen_read, 5'b00100);
        req = 5'b00001;
        src_flit[0] = {SGL, 32'h01};
        for (int c = 0; c < 3; c++) begin
            cycle(); check_eq("bub_idle", seen_read, 5'b00000);
        end
        req = 5'b00101;
        src_flit[2] = {PAY, 32'h22};
        cycle(); check_eq("bub_pay", seen_read, 5'b00100);
        src_flit[2] = {LST, 32'h23};
        cycle(); check_eq("bub_last", seen_read, 5'b00100);
        req = 5'b00001;
        cycle(); check_eq("bub_other", seen_read, 5'b00001);

        // Backpressure
        src_flit[0] = {SGL, 32'h51};
        cycle();
        out_ready = 1'b0;
        src_flit[0] = {SGL, 32'h52};
        for (int c = 0; c < 4; c++) begin
            cycle();
            check_eq("bp_read", seen_read, 5'b00000);
            check_eq("bp_hold", out_flit, {SGL, 32'h51});
        end
        out_ready = 1'b1;
        cycle();
        check_eq("bp_release", seen_read, 5'b00001);
        check_eq("bp_new_flit", out_flit, {SGL, 32'h52});
        check_eq("bp_new_valid", out_valid, 1);

        // Asynchronous reset in the middle of a packet
        do_reset();
        req = 5'b00010;
        src_flit[1] = {HDR, 32'h61};
        cycle();
        check_eq("ar_locked", dut.locked_r, 1);
        req = 5'b01010;
        src_flit[1] = {SGL, 32'h62};
        src_flit[3] = {SGL, 32'h63};
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("ar_unlock", dut.locked_r, 0);
        check_eq("ar_valid", out_valid, 0);
        check_eq("ar_read", switch_read, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        check_eq("ar_lowest", seen_read, 5'b00010);

        // Random traffic with random downstream stalls
        for (int i = 0; i < NP; i++) begin
            len[i] = $urandom_range(1, 4);
            pos[i] = 0;
            dat[i] = $urandom;
        end
        src_update('0);
        for (int c = 0; c < 3000; c++) begin
            cycle();
            src_update(last_read);
            out_ready = ($urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
